// File: rtl/count_monitor.sv
// count_monitor: step checker for the 4-bit enable-driven counter.
// Flags illegal steps, counts wraps and serves a four-phase count/wrap snapshot.
module count_monitor #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              count_rst,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              snap_req,
    input  logic              err_clr,
    output logic              snap_valid,
    output logic [WIDTH-1:0]  snap_count,
    output logic [WRAP_W-1:0] snap_wraps,
    output logic              wrap_pulse,
    output logic              step_err
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    prev_count_q, prev_count_d;
    logic                prev_en_q, prev_en_d;
    logic                prev_rst_q, prev_rst_d;
    logic                armed_q, armed_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;
    logic                wrap_pulse_q, wrap_pulse_d;
    logic                step_err_q, step_err_d;
    logic                snap_valid_q;
    logic [WIDTH-1:0]    snap_count_q;
    logic [WRAP_W-1:0]   snap_wraps_q;

    logic [WIDTH-1:0]    inc_count;
    logic                err_hit;
    logic                wrap_hit;

    // Step legality, wrap detection and next value of the tracking state
    always_comb begin
        inc_count    = prev_count_q + WIDTH'(1);
        err_hit      = 1'b0;
        if (armed_q) begin
            if (prev_rst_q) begin
                err_hit = (count_in != '0);
            end else if (prev_en_q) begin
                err_hit = (count_in != inc_count);
            end else begin
                err_hit = (count_in != prev_count_q);
            end
        end
        // A counter reset landing on 0 is excluded by the prev_rst term
        wrap_hit     = armed_q && !prev_rst_q && prev_en_q &&
                       (prev_count_q == '1) && (count_in == '0);
        wraps_d      = wraps_q;
        if (wrap_hit && (wraps_q != '1)) begin
            wraps_d = wraps_q + WRAP_W'(1);
        end
        wrap_pulse_d = wrap_hit;
        // A new error beats a simultaneous clear
        step_err_d   = step_err_q;
        if (err_hit) begin
            step_err_d = 1'b1;
        end else if (err_clr) begin
            step_err_d = 1'b0;
        end
        prev_count_d = count_in;
        prev_en_d    = enable;
        prev_rst_d   = count_rst;
        armed_d      = 1'b1;
    end

    // Tracking and status registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_count_q <= '0;
            prev_en_q    <= 1'b0;
            prev_rst_q   <= 1'b0;
            armed_q      <= 1'b0;
            wraps_q      <= '0;
            wrap_pulse_q <= 1'b0;
            step_err_q   <= 1'b0;
        end else begin
            prev_count_q <= prev_count_d;
            prev_en_q    <= prev_en_d;
            prev_rst_q   <= prev_rst_d;
            armed_q      <= armed_d;
            wraps_q      <= wraps_d;
            wrap_pulse_q <= wrap_pulse_d;
            step_err_q   <= step_err_d;
        end
    end

    // Snapshot handshake: capture on request, freeze until request drops
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            snap_valid_q <= 1'b0;
            snap_count_q <= '0;
            snap_wraps_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (snap_req) begin
                        state_q      <= S_HOLD;
                        snap_valid_q <= 1'b1;
                        snap_count_q <= count_in;
                        snap_wraps_q <= wraps_d;
                    end
                end
                S_HOLD: begin
                    if (!snap_req) begin
                        state_q      <= S_IDLE;
                        snap_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    snap_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign snap_valid = snap_valid_q;
    assign snap_count = snap_count_q;
    assign snap_wraps = snap_wraps_q;
    assign wrap_pulse = wrap_pulse_q;
    assign step_err   = step_err_q;

endmodule
